// File: rtl/dff_pipe_r.sv
// Elastic register pipeline: DEPTH valid/ready stages of WIDTH bits with a collapsing ready chain.
// Optional synchronous flush port enabled by defining DFF_PIPE_FLUSH_EN.

module dff_pipe_r_stage #(
  parameter int unsigned      WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      valid <= 1'b0;
      data  <= RESET_VALUE;
    end else if (load) begin
      valid <= up_valid;
      // an empty slot passing through keeps the old word, keeping data toggling down
      if (up_valid) data <= up_data;
    end
  end
endmodule

module dff_pipe_r #(
  parameter int unsigned      WIDTH       = 4,
  parameter int unsigned      DEPTH       = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
`ifdef DFF_PIPE_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             out_ready
);
  // index 0 is the upstream port, index i+1 is the output of stage i
  logic [DEPTH:0]            vld_pipe;
  logic [DEPTH:0][WIDTH-1:0] dat_pipe;
  logic [DEPTH:0]            rdy;
  logic                      clr;

`ifdef DFF_PIPE_FLUSH_EN
  assign clr = flush;
`else
  assign clr = 1'b0;
`endif

  assign vld_pipe[0] = in_valid;
  assign dat_pipe[0] = in_data;
  assign rdy[DEPTH]  = out_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stg
    assign rdy[i] = ~vld_pipe[i+1] | rdy[i+1];

    dff_pipe_r_stage #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE)
    ) u_stg (
      .clk      (clk),
      .reset    (reset),
      .clr      (clr),
      .load     (rdy[i]),
      .up_valid (vld_pipe[i]),
      .up_data  (dat_pipe[i]),
      .valid    (vld_pipe[i+1]),
      .data     (dat_pipe[i+1])
    );
  end

  assign in_ready  = rdy[0] & ~clr;
  assign out_valid = vld_pipe[DEPTH];
  assign out_data  = dat_pipe[DEPTH];
endmodule

// File: tb/tb_dff_pipe_r.sv
// Directed bench for dff_pipe_r (WIDTH=4, DEPTH=2), with RESET_VALUE=F and DEPTH=1 side instances.
// Define DFF_PIPE_FLUSH_EN to exercise the flush port.

module tb_dff_pipe_r;
  logic       clk = 1'b0;
  logic       reset, in_valid, out_ready, flush;
  logic [3:0] in_data;
  logic       in_ready, out_valid, in_ready_f, out_valid_f, in_ready_1, out_valid_1;
  logic [3:0] out_data, out_data_f, out_data_1;
  int         n_vec = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  dff_pipe_r #(.WIDTH(4), .DEPTH(2), .RESET_VALUE(4'h0)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data),
`ifdef DFF_PIPE_FLUSH_EN
    .flush(flush),
`endif
    .out_ready(out_ready));

  dff_pipe_r #(.WIDTH(4), .DEPTH(2), .RESET_VALUE(4'hF)) u_dut_f (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_f),
    .out_valid(out_valid_f), .out_data(out_data_f),
`ifdef DFF_PIPE_FLUSH_EN
    .flush(flush),
`endif
    .out_ready(out_ready));

  dff_pipe_r #(.WIDTH(4), .DEPTH(1), .RESET_VALUE(4'h0)) u_dut_1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_1),
    .out_valid(out_valid_1), .out_data(out_data_1),
`ifdef DFF_PIPE_FLUSH_EN
    .flush(flush),
`endif
    .out_ready(out_ready));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // advance one edge and settle past it
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = 4'h0; out_ready = 1'b1; flush = 1'b0;

    // reset state
    cyc(); cyc();
    chk("rst_ov", out_valid, 0);
    chk("rst_od", out_data, 4'h0);
    chk("rst_od_f", out_data_f, 4'hF);
    reset = 1'b0; #1;
    chk("rst_ir", in_ready, 1);

    // streaming A,5,3 with out_ready=1: A visible after the second edge
    in_valid = 1'b1; in_data = 4'hA; cyc();
    chk("st_ov0", out_valid, 0);
    in_data = 4'h5; cyc();
    chk("st_ov1", out_valid, 1);
    chk("st_d1", out_data, 4'hA);
    in_data = 4'h3; cyc();
    chk("st_d2", out_data, 4'h5);
    in_valid = 1'b0; cyc();
    chk("st_d3", out_data, 4'h3);
    cyc();
    chk("st_empty", out_valid, 0);

    // backpressure: 1,2 accepted, 3 stalled, then drained in order
    out_ready = 1'b0; in_valid = 1'b1; in_data = 4'h1; #1;
    chk("bp_ir1", in_ready, 1);
    cyc();
    chk("d1_ir", in_ready_1, 0);
    chk("d1_od", out_data_1, 4'h1);
    in_data = 4'h2; #1;
    chk("bp_ir2", in_ready, 1);
    cyc();
    in_data = 4'h3; #1;
    chk("bp_ir3", in_ready, 0);
    cyc();
    chk("bp_hold_ir", in_ready, 0);
    chk("bp_hold_d", out_data, 4'h1);
    out_ready = 1'b1; #1;
    chk("bp_rel_ir", in_ready, 1);
    cyc();
    in_valid = 1'b0;
    chk("bp_o2", out_data, 4'h2);
    cyc();
    chk("bp_o3", out_data, 4'h3);
    cyc();
    chk("bp_empty", out_valid, 0);

    // full pipe, simultaneous in/out for 8 cycles
    out_ready = 1'b0; in_valid = 1'b1; in_data = 4'h0; cyc();
    in_data = 4'h1; cyc();
    out_ready = 1'b1;
    for (int k = 2; k < 10; k++) begin
      in_data = 4'(k); #1;
      chk("full_ir", in_ready, 1);
      cyc();
      chk("full_ov", out_valid, 1);
      chk("full_od", out_data, 32'(k - 1));
    end
    in_valid = 1'b0; cyc();
    chk("full_last", out_data, 4'h9);
    cyc();
    chk("full_empty", out_valid, 0);

    // reset while two words are held
    out_ready = 1'b0; in_valid = 1'b1; in_data = 4'h6; cyc();
    in_data = 4'h7; cyc();
    in_valid = 1'b0;
    chk("mr_held", out_data_f, 4'h6);
    reset = 1'b1; cyc();
    chk("mr_ov", out_valid, 0);
    chk("mr_od", out_data, 4'h0);
    chk("mr_ov_f", out_valid_f, 0);
    chk("mr_od_f", out_data_f, 4'hF);
    reset = 1'b0; out_ready = 1'b1; cyc();
    chk("mr_after", out_valid, 0);

`ifdef DFF_PIPE_FLUSH_EN
    // flush discards held words and blocks the word offered that cycle
    out_ready = 1'b0; in_valid = 1'b1; in_data = 4'h8; cyc();
    in_data = 4'h9; cyc();
    flush = 1'b1; in_data = 4'h7; #1;
    chk("fl_ir", in_ready, 0);
    chk("fl_ov_pre", out_valid, 1);
    cyc();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("fl_ov", out_valid, 0);
    chk("fl_od", out_data, 4'h0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("fl_no7", out_valid, 0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
